// File: rtl/sprite_plotter.sv
// Sprite drawing stage: restores background (from a synchronous ROM) or paints a solid
// character square, one pixel per cycle. Define CLIP_EN to suppress off-screen plots.
module sprite_plotter #(
  parameter int                  SPRITE_W    = 4,
  parameter int                  SPRITE_H    = 4,
  parameter int                  COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] CHAR_COLOUR = 3'b111,
  parameter int                  SCREEN_W    = 320,
  parameter int                  SCREEN_H    = 240
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic [16:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [8:0]          plot_x,
  output logic [7:0]          plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot,
  output logic                doneBG,
  output logic                doneChar
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  typedef enum logic {MODE_CHAR, MODE_BG} mode_t;

  state_t              r_state, w_nextState;
  mode_t               r_mode;
  logic [3:0]          r_dx, r_dy, w_nextDx, w_nextDy;
  logic [8:0]          r_ox, w_pixX, w_nextX;
  logic [7:0]          r_oy, w_pixY, w_nextY;
  logic                w_lastCol, w_lastPix, w_inRange;
  logic [16:0]         r_bgAddr;
  logic [8:0]          r_plotX;
  logic [7:0]          r_plotY;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot, r_doneBG, r_doneChar;

  function automatic logic [16:0] pixelAddr(input logic [8:0] x, input logic [7:0] y);
    logic [16:0] yWide;
    yWide = {9'd0, y};
    return (yWide << 8) + (yWide << 6) + {8'd0, x};
  endfunction

  assign w_lastCol = (r_dx == 4'(SPRITE_W - 1));
  assign w_lastPix = w_lastCol && (r_dy == 4'(SPRITE_H - 1));
  assign w_nextDx  = w_lastCol ? 4'd0 : r_dx + 4'd1;
  assign w_nextDy  = w_lastCol ? r_dy + 4'd1 : r_dy;
  assign w_pixX    = r_ox + {5'd0, r_dx};
  assign w_pixY    = r_oy + {4'd0, r_dy};
  assign w_nextX   = r_ox + {5'd0, w_nextDx};
  assign w_nextY   = r_oy + {4'd0, w_nextDy};

`ifdef CLIP_EN
  assign w_inRange = (32'(w_pixX) < SCREEN_W) && (32'(w_pixY) < SCREEN_H);
`else
  // Without clipping every pixel is accepted; the screen size is only a sanity guard here.
  assign w_inRange = (SCREEN_W > 0) && (SCREEN_H > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (drawBG || drawChar) w_nextState = SCAN;
      SCAN:    if (w_lastPix) w_nextState = FLUSH;
      FLUSH:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // bg_addr runs one pixel ahead of the plot registers to cover the ROM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode     <= MODE_CHAR;
      r_dx       <= '0;
      r_dy       <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_bgAddr   <= '0;
      r_plotX    <= '0;
      r_plotY    <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
      r_doneBG   <= 1'b0;
      r_doneChar <= 1'b0;
    end else begin
      r_plot     <= 1'b0;
      r_doneBG   <= 1'b0;
      r_doneChar <= 1'b0;
      case (r_state)
        IDLE: begin
          if (drawBG || drawChar) begin
            r_ox   <= xCoordinate;
            r_oy   <= yCoordinate;
            r_dx   <= '0;
            r_dy   <= '0;
            r_mode <= drawBG ? MODE_BG : MODE_CHAR;
            if (drawBG) r_bgAddr <= pixelAddr(xCoordinate, yCoordinate);
          end
        end
        SCAN: begin
          r_plotX <= w_pixX;
          r_plotY <= w_pixY;
          r_plot  <= w_inRange;
          if (r_mode == MODE_CHAR) r_colour <= CHAR_COLOUR;
          r_dx    <= w_lastPix ? 4'd0 : w_nextDx;
          r_dy    <= w_lastPix ? 4'd0 : w_nextDy;
          if (r_mode == MODE_BG && !w_lastPix) r_bgAddr <= pixelAddr(w_nextX, w_nextY);
        end
        FLUSH: begin
          r_doneBG   <= (r_mode == MODE_BG);
          r_doneChar <= (r_mode == MODE_CHAR);
        end
        default: ;
      endcase
    end
  end

  assign bg_addr     = r_bgAddr;
  assign plot_x      = r_plotX;
  assign plot_y      = r_plotY;
  assign plot        = r_plot;
  assign plot_colour = (r_mode == MODE_BG) ? bg_data : r_colour;
  assign doneBG      = r_doneBG;
  assign doneChar    = r_doneChar;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: vector table, hand-written reset abort, and
// randomized requests checked against a pixel-list model of the drawing rules.
module tb_sprite_plotter;

  localparam int W = 4;
  localparam int H = 4;
  localparam int CHAR_C = 7;

  logic        clock = 1'b0;
  logic        reset, drawBG, drawChar;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic [16:0] bgAddr;
  logic [2:0]  bgData;
  logic [8:0]  plotX;
  logic [7:0]  plotY;
  logic [2:0]  plotColour;
  logic        plot, doneBG, doneChar;

  int total = 0;
  int bad   = 0;

  sprite_plotter dut (
    .clock(clock), .reset(reset), .drawBG(drawBG), .drawChar(drawChar),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
    .bg_addr(bgAddr), .bg_data(bgData),
    .plot_x(plotX), .plot_y(plotY), .plot_colour(plotColour), .plot(plot),
    .doneBG(doneBG), .doneChar(doneChar)
  );

  always #5 clock = ~clock;

  // background ROM stand-in: data is the low address bits, one cycle late
  always @(posedge clock) bgData <= bgAddr[2:0];

  function automatic int pixX(int ox, int p);
    return (ox + p % W) % 512;
  endfunction

  function automatic int pixY(int oy, int p);
    return (oy + p / W) % 256;
  endfunction

  function automatic int pixAddr(int x, int y);
    return (y * 320 + x) % 131072;
  endfunction

  function automatic bit pixOn(int x, int y);
`ifdef CLIP_EN
    return (x < 320) && (y < 240);
`else
    return (x >= 0) && (y >= 0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit reqBG, input bit reqChar, input int ox, input int oy,
                               input int pokeAt, output int plots, output int nDoneBG,
                               output int nDoneChar);
    bit isBG;
    int x, y;
    isBG = reqBG;
    @(negedge clock);
    drawBG = reqBG; drawChar = reqChar;
    xCoordinate = 9'(ox); yCoordinate = 8'(oy);
    @(negedge clock);
    drawBG = 1'b0; drawChar = 1'b0;
    xCoordinate = 9'($urandom); yCoordinate = 8'($urandom);
    if (isBG) checkOutput("addr_first", 32'(bgAddr), 32'(pixAddr(pixX(ox, 0), pixY(oy, 0))));
    checkOutput("plot_before", 32'(plot), 32'(0));
    plots = 0; nDoneBG = 0; nDoneChar = 0;
    for (int n = 1; n <= W * H + 1; n++) begin
      @(negedge clock);
      drawChar = (n == pokeAt);
      if (plot) plots++;
      if (doneBG) nDoneBG++;
      if (doneChar) nDoneChar++;
      if (n <= W * H) begin
        x = pixX(ox, n - 1);
        y = pixY(oy, n - 1);
        checkOutput("plot_en", 32'(plot), 32'(pixOn(x, y)));
        if (pixOn(x, y)) begin
          checkOutput("plot_x", 32'(plotX), 32'(x));
          checkOutput("plot_y", 32'(plotY), 32'(y));
          checkOutput("colour", 32'(plotColour), isBG ? 32'(pixAddr(x, y) % 8) : 32'(CHAR_C));
        end
        if (isBG && n < W * H)
          checkOutput("bg_addr", 32'(bgAddr), 32'(pixAddr(pixX(ox, n), pixY(oy, n))));
        checkOutput("done_early", 32'({doneBG, doneChar}), 32'(0));
      end else begin
        checkOutput("done_bg", 32'(doneBG), 32'(isBG));
        checkOutput("done_char", 32'(doneChar), 32'(!isBG));
        checkOutput("plot_at_done", 32'(plot), 32'(0));
      end
    end
    drawChar = 1'b0;
    @(negedge clock);
    if (doneBG) nDoneBG++;
    if (doneChar) nDoneChar++;
    checkOutput("done_after", 32'({doneBG, doneChar}), 32'(0));
  endtask

  typedef struct {
    bit reqBG;
    bit reqChar;
    int ox;
    int oy;
    int pokeAt;
    int expPlots;
  } opVec_t;

  opVec_t vecs[7];

  initial begin
    int plots, nBG, nChar, expPlots, ox, oy;
    bit rb, rc;

`ifdef CLIP_EN
    vecs[0] = '{1, 0,   1,  16, 0, 16};
    vecs[1] = '{0, 1,   2,  17, 0, 16};
    vecs[2] = '{0, 1, 318,  10, 0,  8};
    vecs[3] = '{1, 1, 100,  50, 0, 16};
    vecs[4] = '{1, 0,  20,  30, 5, 16};
    vecs[5] = '{1, 0, 317, 238, 0,  6};
    vecs[6] = '{0, 1, 510, 254, 0,  4};
`else
    vecs[0] = '{1, 0,   1,  16, 0, 16};
    vecs[1] = '{0, 1,   2,  17, 0, 16};
    vecs[2] = '{0, 1, 318,  10, 0, 16};
    vecs[3] = '{1, 1, 100,  50, 0, 16};
    vecs[4] = '{1, 0,  20,  30, 5, 16};
    vecs[5] = '{1, 0, 317, 238, 0, 16};
    vecs[6] = '{0, 1, 510, 254, 0, 16};
`endif

    reset = 1'b1; drawBG = 1'b0; drawChar = 1'b0;
    xCoordinate = '0; yCoordinate = '0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_plot", 32'(plot), 32'(0));
    checkOutput("rst_done", 32'({doneBG, doneChar}), 32'(0));
    checkOutput("rst_xy", 32'({plotX, plotY}), 32'(0));
    checkOutput("rst_colour", 32'(plotColour), 32'(0));
    checkOutput("rst_addr", 32'(bgAddr), 32'(0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].reqBG, vecs[i].reqChar, vecs[i].ox, vecs[i].oy, vecs[i].pokeAt,
                    plots, nBG, nChar);
      checkOutput("vec_plots", 32'(plots), 32'(vecs[i].expPlots));
      checkOutput("vec_nbg", 32'(nBG), 32'(vecs[i].reqBG));
      checkOutput("vec_nchar", 32'(nChar), 32'(!vecs[i].reqBG));
    end

    // abort a character scan with reset in cycle 8
    @(negedge clock);
    drawChar = 1'b1; xCoordinate = 9'd50; yCoordinate = 8'd60;
    @(negedge clock);
    drawChar = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("plot_pre_reset", 32'(plot), 32'(1));
    reset = 1'b1;
    @(negedge clock);
    checkOutput("plot_post_reset", 32'(plot), 32'(0));
    checkOutput("done_post_reset", 32'(doneChar), 32'(0));
    reset = 1'b0;
    nChar = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (doneChar || plot) nChar++;
    end
    checkOutput("quiet_after_reset", 32'(nChar), 32'(0));
    applyStimulus(1'b1, 1'b0, 40, 70, 0, plots, nBG, nChar);
    checkOutput("post_reset_plots", 32'(plots), 32'(16));
    checkOutput("post_reset_nbg", 32'(nBG), 32'(1));

    for (int r = 0; r < 24; r++) begin
      rb = 1'($urandom);
      rc = 1'($urandom);
      if (!rb) rc = 1'b1;
      ox = int'($urandom_range(0, 511));
      oy = int'($urandom_range(0, 255));
      expPlots = 0;
      for (int p = 0; p < W * H; p++)
        if (pixOn(pixX(ox, p), pixY(oy, p))) expPlots++;
      applyStimulus(rb, rc, ox, oy, int'($urandom_range(0, 16)), plots, nBG, nChar);
      checkOutput("rnd_plots", 32'(plots), 32'(expPlots));
      checkOutput("rnd_done", 32'({nBG[1:0], nChar[1:0]}), rb ? 32'(4'b0100) : 32'(4'b0001));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Drawing stage directly downstream of the sprite movement FSM.
- Consumes the movement FSM's drawBG/drawChar strobes and its xCoordinate/yCoordinate sprite origin.
- Erases the sprite footprint by re-plotting background pixels fetched from an external synchronous background ROM, or paints the character square.
- Emits one-pixel-per-cycle VGA-adapter writes and returns doneBG/doneChar pulses to the FSM.

Parameters:
- SPRITE_W, 4, sprite width in pixels (1..16)
- SPRITE_H, 4, sprite height in pixels (1..16)
- COLOUR_W, 3, colour bits per pixel
- CHAR_COLOUR, 3'b111, solid character colour (COLOUR_W bits)
- SCREEN_W, 320, visible width
- SCREEN_H, 240, visible height

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- drawBG  in  1  request: restore background under sprite at current origin
- drawChar  in  1  request: paint character at current origin
- xCoordinate  in  9  sprite origin X (left column)
- yCoordinate  in  8  sprite origin Y (top row)
- bg_addr  out  17  background ROM address, y*320+x
- bg_data  in  COLOUR_W  ROM output, valid the cycle after bg_addr
- plot_x  out  9  pixel X to VGA adapter
- plot_y  out  8  pixel Y to VGA adapter
- plot_colour  out  COLOUR_W  pixel colour
- plot  out  1  write enable to VGA adapter
- doneBG  out  1  one-cycle pulse: background restore complete
- doneChar  out  1  one-cycle pulse: character draw complete

Behaviour:
- Reset (synchronous, active-high; wins over everything): state IDLE, counters 0; plot, doneBG, doneChar, plot_x, plot_y, plot_colour, bg_addr = 0.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - drawBG=1 → latch origin, mode=BG, go SCAN.
  - else drawChar=1 → mode=CHAR, go SCAN.
  - Both high: BG wins, drawChar dropped.
- Requests while not IDLE are ignored, with no queueing.
- SCAN:
  - Offset counters dx (fastest), dy step row-major over SPRITE_W*SPRITE_H pixels, one per cycle.
  - bg_addr = (oy+dy)*320 + (ox+dx), computed as (y<<8)+(y<<6)+x, truncated to 17 bits.
  - bg_addr is driven in BG mode only; it holds its last value in CHAR mode.
  - After the last pixel (dx=W-1, dy=H-1), go FLUSH.
- Pipeline: one stage.
  - The pixel addressed in cycle k is plotted in cycle k+1: plot_x/plot_y/plot are registered.
  - plot_colour = bg_data (BG mode) or registered CHAR_COLOUR (CHAR mode).
- FLUSH: emits the final plot, then goes to DONE.
- DONE: pulse doneBG or doneChar (per mode) for exactly one cycle, plot=0, return to IDLE.
- Latency: request sampled at edge E0.
  - Plots occur in the cycles following E1..E(W*H).
  - Done pulse in the cycle following E(W*H+1). For 4x4 that is 16 plot cycles, with done in cycle 17.
  - A new request is accepted the cycle after done.
- Coordinates: ox+dx computed 9-bit, oy+dy 8-bit (wraps mod 512/256 before clipping check).
- Reset mid-operation: abort immediately; no done pulse; plot low from the next cycle.
- The movement FSM holds xCoordinate/yCoordinate stable during a request. The block latches the origin anyway and ignores later changes.

Optional Feature:
- Macro: CLIP_EN.
- Defined: pixels with x>=SCREEN_W or y>=SCREEN_H have plot forced 0. They are still counted, so latency is unchanged and the done pulse still fires.
- Undefined: plot asserted for every pixel; out-of-range coordinates are passed through wrapped, and bg_addr wraps mod 2^17.

Test Plan:
- Reset, then drawBG with origin (1,16) and bg_data driven as addr[2:0]:
  - bg_addr sequence 5121,5122,5123,5124,5441,…,6084.
  - 16 plots at (1,16)…(4,19) with colour matching the previous-cycle address.
  - doneBG high exactly in cycle 17; doneChar stays 0.
- drawChar at (2,17): 16 plots at (2,17),(3,17),(4,17),(5,17),(2,18)…(5,20), colour 3'b111; doneChar in cycle 17.
- CLIP_EN, drawChar at (318,10): only x=318,319 plotted (8 plots); doneChar still in cycle 17. Without CLIP_EN: 16 plots.
- drawBG and drawChar asserted in the same cycle → BG scan only, single doneBG, no doneChar.
- drawChar pulsed in cycle 5 of a BG scan → ignored; scan unaffected; no doneChar.
- reset asserted in cycle 8 of a CHAR scan → plot=0 next cycle, no doneChar. A following drawBG completes normally in 17 cycles.
